// File: rtl/csr_pkg.sv
// Shared CSR address map, func3 operation encodings and the read-modify-write helper.
package csr_pkg;

    typedef enum logic [11:0] {
        CSR_MSTATUS = 12'h300,
        CSR_MIE     = 12'h304,
        CSR_MTVEC   = 12'h305,
        CSR_MEPC    = 12'h341,
        CSR_MCAUSE  = 12'h342,
        CSR_CYCLE   = 12'hC00,
        CSR_CYCLEH  = 12'hC80
    } csr_addr_t;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    localparam logic [31:0] MCAUSE_EXT_INT = 32'h8000_000B;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MEIE     = 11;

    function automatic logic [31:0] apply_op(input logic [1:0] op,
                                             input logic [31:0] old_val,
                                             input logic [31:0] operand);
        case (op)
            OP_RW:   apply_op = operand;
            OP_SET:  apply_op = old_val | operand;
            OP_CLR:  apply_op = old_val & ~operand;
            default: apply_op = old_val;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// Free-running 64-bit cycle counter, cleared by synchronous reset.
module csr_counter64 (
    input  logic        clk,
    input  logic        RST,
    output logic [63:0] count
);

    always_ff @(posedge clk) begin
        if (RST)
            count <= 64'd0;
        else
            count <= count + 64'd1;
    end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: mstatus/mie/mtvec/mepc/mcause plus read-only cycle counter,
// with interrupt entry and mret side effects prioritised over software writes.
module csr_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        csr_WE,
    input  logic        int_taken,
    input  logic        mret_exec,
    input  logic [2:0]  func3,
    input  logic [11:0] addr,
    input  logic [31:0] wd,
    input  logic [31:0] pc,
    output logic [31:0] rd,
    output logic [31:0] mepc,
    output logic [31:0] mtvec,
    output logic        intr_en
);

    logic        status_mie, status_mpie, meie;
    logic [31:0] mtvec_q, mepc_q, mcause_q;
    logic        status_mie_n, status_mpie_n, meie_n;
    logic [31:0] mtvec_n, mepc_n, mcause_n;
    logic [31:0] wr_val;
    logic [63:0] count;

    csr_counter64 u_counter (
        .clk   (clk),
        .RST   (RST),
        .count (count)
    );

    always_comb begin
        rd = 32'd0;
        case (addr)
            CSR_MSTATUS: begin
                rd[MSTATUS_MIE]  = status_mie;
                rd[MSTATUS_MPIE] = status_mpie;
            end
            CSR_MIE:     rd[MIE_MEIE] = meie;
            CSR_MTVEC:   rd = mtvec_q;
            CSR_MEPC:    rd = mepc_q;
            CSR_MCAUSE:  rd = mcause_q;
            CSR_CYCLE:   rd = count[31:0];
            CSR_CYCLEH:  rd = count[63:32];
            default:     rd = 32'd0;
        endcase
    end

    // The write value is derived from rd, so unmapped addresses read as zero and are simply not stored.
    always_comb begin
        wr_val        = apply_op(func3[1:0], rd, wd);
        status_mie_n  = status_mie;
        status_mpie_n = status_mpie;
        meie_n        = meie;
        mtvec_n       = mtvec_q;
        mepc_n        = mepc_q;
        mcause_n      = mcause_q;
        if (int_taken) begin
            mepc_n        = {pc[31:2], 2'b00};
            status_mpie_n = status_mie;
            status_mie_n  = 1'b0;
            mcause_n      = MCAUSE_EXT_INT;
        end else if (mret_exec) begin
            status_mie_n  = status_mpie;
            status_mpie_n = 1'b1;
        end else if (csr_WE && func3[1:0] != OP_NONE) begin
            case (addr)
                CSR_MSTATUS: begin
                    status_mie_n  = wr_val[MSTATUS_MIE];
                    status_mpie_n = wr_val[MSTATUS_MPIE];
                end
                CSR_MIE:     meie_n   = wr_val[MIE_MEIE];
                CSR_MTVEC:   mtvec_n  = {wr_val[31:2], 2'b00};
                CSR_MEPC:    mepc_n   = {wr_val[31:2], 2'b00};
                CSR_MCAUSE:  mcause_n = wr_val;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            status_mie  <= 1'b0;
            status_mpie <= 1'b0;
            meie        <= 1'b0;
            mtvec_q     <= {MTVEC_RST[31:2], 2'b00};
            mepc_q      <= 32'd0;
            mcause_q    <= 32'd0;
        end else begin
            status_mie  <= status_mie_n;
            status_mpie <= status_mpie_n;
            meie        <= meie_n;
            mtvec_q     <= mtvec_n;
            mepc_q      <= mepc_n;
            mcause_q    <= mcause_n;
        end
    end

    assign mepc    = mepc_q;
    assign mtvec   = mtvec_q;
    assign intr_en = status_mie & meie;

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed scenarios plus a per-cycle reference model.
module tb_csr_unit;

    localparam logic [31:0] MTVEC_RST = 32'h0000_1003;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        csr_WE = 1'b0, int_taken = 1'b0, mret_exec = 1'b0;
    logic [2:0]  func3 = 3'd0;
    logic [11:0] addr = 12'h300;
    logic [31:0] wd = 32'd0, pc = 32'd0;
    logic [31:0] rd, mepc, mtvec;
    logic        intr_en;

    int checks = 0;
    int failures = 0;

    // Reference state, kept as plain architectural values
    bit          m_valid = 1'b0;
    bit          m_mie, m_mpie, m_meie;
    logic [31:0] m_mtvec, m_mepc, m_mcause;
    logic [63:0] m_cnt;

    csr_unit #(.MTVEC_RST(MTVEC_RST)) dut (
        .clk       (clk),
        .RST       (RST),
        .csr_WE    (csr_WE),
        .int_taken (int_taken),
        .mret_exec (mret_exec),
        .func3     (func3),
        .addr      (addr),
        .wd        (wd),
        .pc        (pc),
        .rd        (rd),
        .mepc      (mepc),
        .mtvec     (mtvec),
        .intr_en   (intr_en)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
            12'h304: return m_meie ? 32'h800 : 32'h0;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hC00: return m_cnt[31:0];
            12'hC80: return m_cnt[63:32];
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Model advances on each rising edge, then the DUT is compared against it shortly after
    initial begin
        logic [31:0] old_v, new_v;
        forever begin
            @(posedge clk);
            if (RST) begin
                m_mie = 0; m_mpie = 0; m_meie = 0;
                m_mtvec = MTVEC_RST & 32'hFFFF_FFFC;
                m_mepc = 0; m_mcause = 0; m_cnt = 0;
                m_valid = 1'b1;
            end else if (m_valid) begin
                old_v = model_read(addr);
                case (func3[1:0])
                    2'b01:   new_v = wd;
                    2'b10:   new_v = old_v | wd;
                    2'b11:   new_v = old_v & ~wd;
                    default: new_v = old_v;
                endcase
                if (int_taken) begin
                    m_mepc = pc & 32'hFFFF_FFFC;
                    m_mpie = m_mie;
                    m_mie = 0;
                    m_mcause = 32'h8000_000B;
                end else if (mret_exec) begin
                    m_mie = m_mpie;
                    m_mpie = 1;
                end else if (csr_WE && func3[1:0] != 2'b00) begin
                    if (addr == 12'h300) begin m_mie = new_v[3]; m_mpie = new_v[7]; end
                    if (addr == 12'h304) m_meie = new_v[11];
                    if (addr == 12'h305) m_mtvec = new_v & 32'hFFFF_FFFC;
                    if (addr == 12'h341) m_mepc = new_v & 32'hFFFF_FFFC;
                    if (addr == 12'h342) m_mcause = new_v;
                end
                m_cnt = m_cnt + 64'd1;
            end
            #2;
            if (m_valid) begin
                check_output("model_rd", rd, model_read(addr));
                check_output("model_mepc", mepc, m_mepc);
                check_output("model_mtvec", mtvec, m_mtvec);
                check_output("model_intr_en", {31'd0, intr_en}, {31'd0, m_mie & m_meie});
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic it, input logic mr, input logic [2:0] f3,
                                 input logic [11:0] a, input logic [31:0] w, input logic [31:0] p);
        @(negedge clk);
        csr_WE = we; int_taken = it; mret_exec = mr;
        func3 = f3; addr = a; wd = w; pc = p;
    endtask

    task automatic idle(input logic [11:0] a);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, a, 32'd0, 32'd0);
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        RST = 1'b0;
        #1;
        check_output("reset_mtvec", mtvec, 32'h0000_1000);
        check_output("reset_mepc", mepc, 32'h0);
        check_output("reset_intr_en", {31'd0, intr_en}, 32'h0);
        check_output("reset_mstatus", rd, 32'h0);

        // csrrw mtvec: old value visible during the write, low bits dropped afterwards
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b001, 12'h305, 32'h0000_0103, 32'd0);
        #1 check_output("mtvec_prewrite_rd", rd, 32'h0000_1000);
        idle(12'h305);
        check_output("mtvec_written", mtvec, 32'h0000_0100);

        // Enable MIE then MEIE; intr_en follows one cycle after the second write
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b010, 12'h300, 32'h8, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b010, 12'h304, 32'h800, 32'd0);
        #1 check_output("intr_en_before", {31'd0, intr_en}, 32'h0);
        idle(12'h304);
        check_output("intr_en_set", {31'd0, intr_en}, 32'h1);
        check_output("mie_read", rd, 32'h800);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b011, 12'h300, 32'h8, 32'd0);
        idle(12'h300);
        check_output("intr_en_cleared", {31'd0, intr_en}, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b010, 12'h300, 32'h8, 32'd0);
        idle(12'h300);
        check_output("mie_reenabled", rd, 32'h8);

        // Interrupt entry and return
        applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, 12'h300, 32'd0, 32'h0000_0A46);
        idle(12'h300);
        check_output("int_mepc", mepc, 32'h0000_0A44);
        check_output("int_mstatus", rd, 32'h80);
        check_output("int_intr_en", {31'd0, intr_en}, 32'h0);
        idle(12'h342);
        check_output("int_mcause", rd, 32'h8000_000B);
        applyStimulus(1'b0, 1'b0, 1'b1, 3'b000, 12'h300, 32'd0, 32'd0);
        idle(12'h300);
        check_output("mret_mstatus", rd, 32'h88);
        check_output("mret_intr_en", {31'd0, intr_en}, 32'h1);

        // All three strobes together: only interrupt entry takes effect
        applyStimulus(1'b1, 1'b1, 1'b1, 3'b001, 12'h341, 32'h5, 32'h0000_1234);
        idle(12'h341);
        check_output("prio_mepc", mepc, 32'h0000_1234);
        check_output("prio_mstatus_int", {31'd0, intr_en}, 32'h0);

        // func3=00 leaves mcause alone; clear op trims bit 31
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 12'h342, 32'hFFFF_FFFF, 32'd0);
        idle(12'h342);
        check_output("op_none_mcause", rd, 32'h8000_000B);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b111, 12'h342, 32'h8000_0000, 32'd0);
        idle(12'h342);
        check_output("clear_mcause", rd, 32'h0000_000B);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b001, 12'h341, 32'hDEAD_BEEF, 32'd0);
        idle(12'h341);
        check_output("mepc_align", mepc, 32'hDEAD_BEEC);

        // Writes to read-only counter and to an unmapped address are ignored
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b001, 12'hC00, 32'h0, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b001, 12'h7FF, 32'hFFFF_FFFF, 32'd0);
        #1 check_output("unmapped_rd", rd, 32'h0);
        idle(12'h7FF);
        check_output("unmapped_rd_after", rd, 32'h0);

        // Preload the counter just below a 32-bit rollover
        idle(12'hC80);
        dut.u_counter.count = 64'h0000_0000_FFFF_FFFD;
        m_cnt = 64'h0000_0000_FFFF_FFFD;
        idle(12'hC80);
        check_output("cycleh_before_roll", rd, 32'h0);
        idle(12'hC80);
        idle(12'hC80);
        check_output("cycleh_after_roll", rd, 32'h1);
        idle(12'hC00);
        check_output("cycle_after_roll", rd, 32'h1);

        // Reset coincident with an interrupt strobe wins
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b001, 12'h300, 32'h8, 32'd0);
        idle(12'h300);
        check_output("pre_reset_intr_en", {31'd0, intr_en}, 32'h1);
        @(negedge clk);
        RST = 1'b1; int_taken = 1'b1; pc = 32'h0000_0ABC;
        @(negedge clk);
        RST = 1'b0; int_taken = 1'b0;
        #1;
        check_output("rst_intr_en", {31'd0, intr_en}, 32'h0);
        check_output("rst_mepc", mepc, 32'h0);
        check_output("rst_mtvec", mtvec, 32'h0000_1000);
        check_output("rst_mstatus", rd, 32'h0);
        idle(12'h342);
        check_output("rst_mcause", rd, 32'h0);
        idle(12'h304);
        check_output("rst_mie", rd, 32'h0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_unit.md
CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 SHALL have parameter MTVEC_RST, default 32'h0000_0000, reset value of mtvec.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port csr_WE  input  1  CSR read-modify-write strobe from the control FSM.
REQ-005 SHALL have port int_taken  input  1  interrupt entry strobe from the control FSM.
REQ-006 SHALL have port mret_exec  input  1  mret strobe from the control FSM.
REQ-007 SHALL have port func3  input  3  ir[14:12]; only bits [1:0] are used: 01 rw, 10 set, 11 clear.
REQ-008 SHALL have port addr  input  12  CSR address, ir[31:20].
REQ-009 SHALL have port wd  input  32  write operand (rs1 value or zero-extended uimm, selected upstream).
REQ-010 SHALL have port pc  input  32  PC saved into mepc on interrupt entry.
REQ-011 SHALL have port rd  output  32  combinational read of the CSR at addr; drives the register-file csr source.
REQ-012 SHALL have port mepc  output  32  current mepc, the PC target for mret.
REQ-013 SHALL have port mtvec  output  32  current mtvec, the PC target for interrupt entry.
REQ-014 SHALL have port intr_en  output  1  mstatus.MIE AND mie.MEIE; gates the raw interrupt before it reaches the control FSM.

Function
REQ-015 SHALL implement the map: 0x300 mstatus (bits 3 MIE, 7 MPIE; others read 0), 0x304 mie (bit 11 MEIE only), 0x305 mtvec, 0x341 mepc, 0x342 mcause, 0xC00 cycle, 0xC80 cycleh.
REQ-016 SHALL return 0 on rd for unmapped addresses and ignore writes to them.
REQ-017 SHALL treat cycle/cycleh as read-only; writes ignored.
REQ-018 SHALL compute the write value from the old value: rw -> wd; set -> old | wd; clear -> old & ~wd.
REQ-019 SHALL update the addressed register on the clock edge where csr_WE=1.
- rd in that cycle shows the pre-write value.
- With func3[1:0]=00, no register changes.
REQ-020 SHALL force mtvec[1:0] and mepc[1:0] to 0 on every write.
REQ-021 SHALL, on the edge where int_taken=1:
- mepc <= {pc[31:2],2'b00}
- MPIE <= MIE
- MIE <= 0
- mcause <= 32'h8000_000B
REQ-022 SHALL, on the edge where mret_exec=1:
- MIE <= MPIE
- MPIE <= 1
REQ-023 SHALL apply priority int_taken > mret_exec > csr_WE when strobes coincide; lower-priority strobes are dropped entirely that cycle.
REQ-024 SHALL drive intr_en from registered state only, so it changes one cycle after the causing strobe.
REQ-025 SHALL increment a 64-bit cycle counter every clock not in reset, wrapping 2^64-1 -> 0.
- cycle = bits[31:0], cycleh = bits[63:32].
REQ-026 SHALL make mepc, mtvec and intr_en outputs combinational views of the registers, with zero latency.

Reset
REQ-027 SHALL, while RST=1 at a clock edge, set:
- mstatus=0, mie=0, mepc=0, mcause=0, counter=0
- mtvec=MTVEC_RST with bits [1:0] cleared
REQ-028 SHALL give RST priority over all strobes; a strobe coincident with RST has no effect.
REQ-029 SHALL hold intr_en=0 from reset until software sets both MIE and MEIE.

Structure
REQ-030 SHALL place CSR address constants (enum csr_addr_t) and the func3 operation encodings in shared package csr_pkg, which the decoder also imports.
REQ-031 SHALL implement the 64-bit counter as sub-module csr_counter64 (clk, RST, count[63:0]).
REQ-032 SHALL register all state in a single clocked block with one combinational next-state block, with no latches.

Verification
REQ-033 Reset, then csrrw 0x305 with wd=32'h0000_0103 -> mtvec=32'h0000_0100 on the next cycle; rd of 0x305 shows the old value during the write cycle.
REQ-034 Set 0x300 wd=8 and set 0x304 wd=32'h800 -> intr_en=1 one cycle after the second write; clear 0x300 wd=8 -> intr_en=0.
REQ-035 With MIE=1, int_taken with pc=32'h0000_0A46 -> mepc=32'h0000_0A44, mstatus=32'h80, mcause=32'h8000_000B, intr_en=0; then mret_exec -> mstatus=32'h88, intr_en=1.
REQ-036 int_taken, mret_exec and csr_WE (rw 0x341, wd=5) all asserted in one cycle -> only the interrupt entry occurs; mepc=pc, not 4.
REQ-037 Write to 0xC00 and to unmapped 0x7FF -> no state change, rd(0x7FF)=0; counter preloaded near 32'hFFFF_FFFF rolls cycleh from 0 to 1.
REQ-038 RST asserted coincident with int_taken after MIE=1 -> every register returns to its reset value and intr_en=0 on the next cycle.
